// File: rtl/if_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue_if
//   Bundles the fetch-side and ID-side signals of the prefetch queue.
//
//   Handshake semantics (single place they are described):
//     out_valid is the "head valid" flag. ID consumes the head entry at a
//     rising edge when out_valid=1 and freeze=0 (freeze acts as an inverted
//     ready). branch_taken overrides both: the head is squashed, not
//     consumed. The instruction-memory side has no handshake. imem_data must
//     be the word at imem_addr within the same cycle.
//
//   Signals:
//     freeze, branch_taken, branch_addr : control from ID / EXE
//     imem_addr / imem_data             : combinational instruction memory
//     out_valid, out_pc, out_inst       : queue head presented to ID
//     occupancy                         : number of valid entries
//
//   Modports:
//     master : the prefetch queue itself
//     slave  : the surrounding pipeline / instruction memory
// ---------------------------------------------------------------------------
interface if_prefetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              freeze;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    input  freeze, branch_taken, branch_addr, imem_data,
    output imem_addr, out_valid, out_pc, out_inst, occupancy
  );

  modport slave (
    output freeze, branch_taken, branch_addr, imem_data,
    input  imem_addr, out_valid, out_pc, out_inst, occupancy
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue
//   Instruction fetch stage with a DEPTH-entry prefetch queue in front of ID.
//   Fetches one word per cycle sequentially from a combinational instruction
//   memory while there is room (or while the head is leaving in the same
//   cycle), presents the oldest entry to ID, and flushes and redirects on a
//   taken branch.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous, active-high reset
//     bus  : if_prefetch_queue_if.master (see the interface for the list)
//
//   Each entry stores {pc + PC_STEP, instruction}. This matches the PC value
//   that the old IF/ID register handed to ID.
// ---------------------------------------------------------------------------
module if_prefetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  if_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] entry_pc_q   [DEPTH];
  logic [ADDR_W-1:0] entry_pc_d   [DEPTH];
  logic [DATA_W-1:0] entry_inst_q [DEPTH];
  logic [DATA_W-1:0] entry_inst_d [DEPTH];

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  // The count is kept apart from the pointers, so that full and empty are
  // never confused when rd_ptr == wr_ptr.
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

  logic              head_valid;
  logic              deq;
  logic              enq;
  logic [ADDR_W-1:0] pc_next;

  assign head_valid = (count_q != '0);
  assign pc_next    = fetch_pc_q + ADDR_W'(PC_STEP);

  always_comb begin
    entry_pc_d   = entry_pc_q;
    entry_inst_d = entry_inst_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fetch_pc_d   = fetch_pc_q;

    deq = head_valid & ~bus.freeze & ~bus.branch_taken;
    // A full queue may still accept a word when the head leaves in the same
    // cycle. This keeps throughput at one word per cycle.
    enq = ~bus.branch_taken & ((count_q < CW'(DEPTH)) | deq);

    if (bus.branch_taken) begin
      // Flush: the head is squashed, not consumed. Fetch restarts at the target.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = bus.branch_addr;
    end else begin
      if (enq) begin
        entry_pc_d[wr_ptr_q]   = pc_next;
        entry_inst_d[wr_ptr_q] = bus.imem_data;
        wr_ptr_d               = wr_ptr_q + PW'(1);
        fetch_pc_d             = pc_next;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_pc_q   <= '{default: '0};
      entry_inst_q <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fetch_pc_q   <= RESET_PC;
    end else begin
      entry_pc_q   <= entry_pc_d;
      entry_inst_q <= entry_inst_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fetch_pc_q   <= fetch_pc_d;
    end
  end

  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = head_valid;
  assign bus.out_pc    = head_valid ? entry_pc_q[rd_ptr_q]   : '0;
  assign bus.out_inst  = head_valid ? entry_inst_q[rd_ptr_q] : '0;
  assign bus.occupancy = count_q;

endmodule
